// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel frame controller.
package sobel_pkg;

    // Frame sequencer states.
    typedef enum logic [2:0] {
        IDLE,
        WAIT_VS,
        FLUSH,
        CAPTURE,
        DROP
    } state_e;

    // Bit positions inside the sticky error vector.
    localparam int ERR_W           = 3;
    localparam int ERR_SHORT_LINE  = 0;
    localparam int ERR_LONG_LINE   = 1;
    localparam int ERR_SHORT_FRAME = 2;

endpackage : sobel_pkg

// File: rtl/sobel_counter.sv
// Up-counter with enable and a synchronous active-low data clear.
// The data clear lets the owner restart the count without a full reset.
module sobel_counter #(
    parameter int W_P = 8
) (
    input  logic           clk_i,
    input  logic           rstn_i,
    input  logic           rstn_data_i,
    input  logic           en_i,
    output logic [W_P-1:0] cnt_o
);

    logic [W_P-1:0] cnt_q;
    logic [W_P-1:0] cnt_d;

    // Next count: clear has priority over increment.
    always_comb begin
        // NOTE: assign a default before any branch so no path leaves cnt_d unassigned (no latch).
        cnt_d = cnt_q;
        if (!rstn_data_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + W_P'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rstn_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule : sobel_counter

// File: rtl/sobel_vsync_edge.sv
// Registered rising-edge detector for vsync.
// History resets high so a vsync already high at reset release is not an edge.
module sobel_vsync_edge (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic vsync_i,
    output logic vs_rise_o
);

    logic vs_q;
    logic vs_d;

    // History simply follows the input every cycle.
    always_comb begin
        vs_d = vsync_i;
    end

    // History register, reset high.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            vs_q <= 1'b1;
        end else begin
            vs_q <= vs_d;
        end
    end

    assign vs_rise_o = vsync_i & ~vs_q;

endmodule : sobel_vsync_edge

// File: rtl/sobel_frame_ctrl.sv
// Frame-level sequencer between the camera FIFO and the conv2d pipeline.
// Waits for sensor configuration, arms on vsync, flushes conv2d line
// buffers between frames and forwards only well-formed frames.
// Optional macro SOBEL_FRAME_CTRL_DECIMATE_EN: process every other frame.
module sobel_frame_ctrl
    import sobel_pkg::*;
#(
    parameter int WIDTH_P     = 8,
    parameter int LINE_W_P    = 640,
    parameter int FRAME_H_P   = 480,
    parameter int FLUSH_CYC_P = 4,
    parameter int FCNT_W_P    = 16
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                cfg_done_i,
    input  logic                vsync_i,
    input  logic [WIDTH_P-1:0]  s_tdata_i,
    input  logic                s_tvalid_i,
    input  logic                s_tlast_i,
    output logic                s_tready_o,
    output logic [WIDTH_P-1:0]  m_tdata_o,
    output logic                m_tvalid_o,
    output logic                m_tuser_o,
    output logic                m_tlast_o,
    input  logic                m_tready_i,
    output logic                flush_o,
    output logic                busy_o,
    output logic [ERR_W-1:0]    err_o,
    input  logic                err_clr_i,
    output logic [FCNT_W_P-1:0] frame_cnt_o
);

    // x may step one past the last pixel on a long line, hence the +1.
    localparam int XW  = $clog2(LINE_W_P + 1);
    localparam int YW  = $clog2(FRAME_H_P + 1);
    localparam int FLW = $clog2(FLUSH_CYC_P + 1);

    localparam logic [XW-1:0]  X_LAST     = XW'(LINE_W_P - 1);
    localparam logic [YW-1:0]  Y_LAST     = YW'(FRAME_H_P - 1);
    localparam logic [FLW-1:0] FLUSH_LOAD = FLW'(FLUSH_CYC_P - 1);

    state_e              state_q, state_d;
    logic [FLW-1:0]      fl_cnt_q, fl_cnt_d;
    logic [ERR_W-1:0]    err_q, err_d, err_set;
    logic [FCNT_W_P-1:0] frame_cnt_q, frame_cnt_d;
    logic                sof_pend_q, sof_pend_d;

    logic          vs_rise;
    logic [XW-1:0] x_cnt;
    logic [YW-1:0] y_cnt;
    logic          capture;
    logic          beat;
    logic          line_end;
    logic          short_line;
    logic          long_line;
    logic          frame_done;
    logic          flush_exit;
    logic          skip_frame;
    logic          toggle_flip;

    sobel_vsync_edge u_vs_edge (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .vsync_i   (vsync_i),
        .vs_rise_o (vs_rise)
    );

    // Pixel position; restarted when FLUSH hands over to CAPTURE.
    sobel_counter #(.W_P(XW)) u_x_cnt (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .rstn_data_i (~(flush_exit | line_end)),
        .en_i        (beat),
        .cnt_o       (x_cnt)
    );

    sobel_counter #(.W_P(YW)) u_y_cnt (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .rstn_data_i (~flush_exit),
        .en_i        (line_end),
        .cnt_o       (y_cnt)
    );

`ifdef SOBEL_FRAME_CTRL_DECIMATE_EN
    logic toggle_q, toggle_d;

    // Parity of accepted frame edges: odd edges (1st, 3rd, ...) are processed.
    always_comb begin
        toggle_d = toggle_q ^ toggle_flip;
    end

    // Decimation parity register.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            toggle_q <= 1'b0;
        end else begin
            toggle_q <= toggle_d;
        end
    end

    assign skip_frame = ~toggle_q;
`else
    assign skip_frame = 1'b0;
`endif

    // Zero-latency stream gating and beat classification.
    always_comb begin
        capture    = (state_q == CAPTURE);
        m_tdata_o  = s_tdata_i;
        m_tlast_o  = s_tlast_i;
        m_tvalid_o = capture & s_tvalid_i;
        s_tready_o = capture ? m_tready_i : 1'b1;
        beat       = capture & s_tvalid_i & m_tready_i;
        line_end   = beat &  s_tlast_i & (x_cnt == X_LAST);
        short_line = beat &  s_tlast_i & (x_cnt != X_LAST);
        long_line  = beat & ~s_tlast_i & (x_cnt == X_LAST);
        frame_done = line_end & (y_cnt == Y_LAST);
        flush_exit = (state_q == FLUSH) && (fl_cnt_q == '0);
        m_tuser_o  = m_tvalid_o & (x_cnt == '0) & (y_cnt == '0) & sof_pend_q;
    end

    // Frame sequencer next-state, flush timer, error and frame-count logic.
    always_comb begin
        state_d     = state_q;
        fl_cnt_d    = fl_cnt_q;
        sof_pend_d  = sof_pend_q;
        err_set     = '0;
        toggle_flip = 1'b0;
        frame_cnt_d = frame_cnt_q + {{(FCNT_W_P-1){1'b0}}, frame_done};

        unique case (state_q)
            IDLE: begin
                if (cfg_done_i) begin
                    state_d = WAIT_VS;
                end
            end
            WAIT_VS: begin
                if (vs_rise) begin
                    state_d     = FLUSH;
                    fl_cnt_d    = FLUSH_LOAD;
                    toggle_flip = 1'b1;
                end
            end
            FLUSH: begin
                if (fl_cnt_q == '0) begin
                    state_d    = skip_frame ? DROP : CAPTURE;
                    sof_pend_d = ~skip_frame;
                end else begin
                    fl_cnt_d = fl_cnt_q - FLW'(1);
                end
            end
            CAPTURE: begin
                if (beat) begin
                    sof_pend_d = 1'b0;
                end
                // A frame edge overrides any beat error on the same cycle;
                // a frame finishing exactly on the edge still counts.
                if (vs_rise) begin
                    state_d  = FLUSH;
                    fl_cnt_d = FLUSH_LOAD;
                    if (!frame_done) begin
                        err_set[ERR_SHORT_FRAME] = 1'b1;
                    end
                end else if (frame_done) begin
                    state_d = WAIT_VS;
                end else if (short_line) begin
                    err_set[ERR_SHORT_LINE] = 1'b1;
                    state_d                 = DROP;
                end else if (long_line) begin
                    err_set[ERR_LONG_LINE] = 1'b1;
                    state_d                = DROP;
                end
            end
            DROP: begin
                if (vs_rise) begin
                    state_d     = FLUSH;
                    fl_cnt_d    = FLUSH_LOAD;
                    toggle_flip = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Clear and set on the same cycle: the new error survives.
        err_d = (err_clr_i ? '0 : err_q) | err_set;
    end

    // Sequencer state and status registers.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q     <= IDLE;
            fl_cnt_q    <= '0;
            err_q       <= '0;
            frame_cnt_q <= '0;
            sof_pend_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            fl_cnt_q    <= fl_cnt_d;
            err_q       <= err_d;
            frame_cnt_q <= frame_cnt_d;
            sof_pend_q  <= sof_pend_d;
        end
    end

    assign flush_o     = (state_q == FLUSH);
    assign busy_o      = (state_q == CAPTURE);
    assign err_o       = err_q;
    assign frame_cnt_o = frame_cnt_q;

endmodule : sobel_frame_ctrl

// File: tb/tb_sobel_frame_ctrl.sv
// Bench for sobel_frame_ctrl with a 4x3 frame and 4-cycle flush.
// Stimulus pushes expected output beats into a queue; a monitor pops and
// compares on every accepted output beat.
module tb_sobel_frame_ctrl;
    import sobel_pkg::*;

    localparam int WIDTH_P     = 8;
    localparam int LINE_W_P    = 4;
    localparam int FRAME_H_P   = 3;
    localparam int FLUSH_CYC_P = 4;
    localparam int FCNT_W_P    = 16;

    logic                clk = 1'b0;
    logic                rstn;
    logic                cfg_done;
    logic                vsync;
    logic [WIDTH_P-1:0]  s_tdata;
    logic                s_tvalid;
    logic                s_tlast;
    logic                s_tready_o;
    logic [WIDTH_P-1:0]  m_tdata_o;
    logic                m_tvalid_o;
    logic                m_tuser_o;
    logic                m_tlast_o;
    logic                m_tready;
    logic                flush_o;
    logic                busy_o;
    logic [ERR_W-1:0]    err_o;
    logic                err_clr;
    logic [FCNT_W_P-1:0] frame_cnt_o;

    typedef struct packed {
        logic [WIDTH_P-1:0] data;
        logic               user;
        logic               last;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_exp;
    int    n_total      = 0;
    int    n_pass       = 0;
    int    flush_cycles = 0;
    int    exp_frames   = 0;
    int    fl_snap;

    always #5 clk = ~clk;

    sobel_frame_ctrl #(
        .WIDTH_P     (WIDTH_P),
        .LINE_W_P    (LINE_W_P),
        .FRAME_H_P   (FRAME_H_P),
        .FLUSH_CYC_P (FLUSH_CYC_P),
        .FCNT_W_P    (FCNT_W_P)
    ) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .cfg_done_i  (cfg_done),
        .vsync_i     (vsync),
        .s_tdata_i   (s_tdata),
        .s_tvalid_i  (s_tvalid),
        .s_tlast_i   (s_tlast),
        .s_tready_o  (s_tready_o),
        .m_tdata_o   (m_tdata_o),
        .m_tvalid_o  (m_tvalid_o),
        .m_tuser_o   (m_tuser_o),
        .m_tlast_o   (m_tlast_o),
        .m_tready_i  (m_tready),
        .flush_o     (flush_o),
        .busy_o      (busy_o),
        .err_o       (err_o),
        .err_clr_i   (err_clr),
        .frame_cnt_o (frame_cnt_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted output beat must match the head of the queue.
    always @(negedge clk) begin
        if (rstn && m_tvalid_o && m_tready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_beat: got data %0h, expected no beat (t=%0t)", m_tdata_o, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                check("beat_data", {24'd0, m_tdata_o}, {24'd0, mon_exp.data});
                check("beat_tuser", {31'd0, m_tuser_o}, {31'd0, mon_exp.user});
                check("beat_tlast", {31'd0, m_tlast_o}, {31'd0, mon_exp.last});
            end
        end
    end

    always @(negedge clk) begin
        if (flush_o) flush_cycles++;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic vs_pulse(input logic clr);
        vsync   = 1'b1;
        err_clr = clr;
        tick();
        vsync   = 1'b0;
        err_clr = 1'b0;
        tick();
    endtask

    task automatic wait_busy();
        for (int i = 0; i < 20 && !busy_o; i++) tick();
        check("busy_after_flush", {31'd0, busy_o}, 32'd1);
    endtask

    // One input beat; fwd says whether it must appear downstream.
    task automatic send_beat(input logic [WIDTH_P-1:0] d, input logic last,
                             input logic fwd, input logic user, input int stall);
        s_tdata  = d;
        s_tlast  = last;
        s_tvalid = 1'b1;
        if (fwd) exp_q.push_back('{data: d, user: user, last: last});
        if (stall > 0) begin
            m_tready = 1'b0;
            for (int k = 0; k < stall; k++) begin
                @(negedge clk);
                check("stall_s_tready", {31'd0, s_tready_o}, 32'd0);
                check("stall_m_tvalid", {31'd0, m_tvalid_o}, 32'd1);
                tick();
            end
            m_tready = 1'b1;
        end
        @(negedge clk);
        check("s_tready", {31'd0, s_tready_o}, 32'd1);
        if (!fwd) check("discard_m_tvalid", {31'd0, m_tvalid_o}, 32'd0);
        tick();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic send_frame(input logic [WIDTH_P-1:0] base, input int stall_idx, input int stall_n);
        for (int i = 0; i < LINE_W_P * FRAME_H_P; i++) begin
            send_beat(base + WIDTH_P'(i), (i % LINE_W_P) == LINE_W_P - 1, 1'b1, i == 0,
                      (i == stall_idx) ? stall_n : 0);
        end
    endtask

    initial begin
        rstn     = 1'b0;
        cfg_done = 1'b0;
        vsync    = 1'b0;
        s_tdata  = '0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        m_tready = 1'b1;
        err_clr  = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_frame_cnt", {16'd0, frame_cnt_o}, 32'd0);
        check("rst_err", {29'd0, err_o}, 32'd0);
        check("rst_flush", {31'd0, flush_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_m_tvalid", {31'd0, m_tvalid_o}, 32'd0);
        tick();
        rstn = 1'b1;
        tick();

        // 1. Not configured: vsync and beats are ignored.
        fl_snap = flush_cycles;
        vs_pulse(1'b0);
        for (int i = 0; i < 10; i++) send_beat(8'hA0 + 8'(i), i % 4 == 3, 1'b0, 1'b0, 0);
        vs_pulse(1'b0);
        for (int i = 0; i < 10; i++) send_beat(8'hB0 + 8'(i), i % 4 == 3, 1'b0, 1'b0, 0);
        check("idle_frame_cnt", {16'd0, frame_cnt_o}, 32'd0);
        check("idle_no_flush", 32'(flush_cycles - fl_snap), 32'd0);
        cfg_done = 1'b1;
        repeat (2) tick();
        fl_snap = flush_cycles;
        vs_pulse(1'b0);
        wait_busy();
        check("flush_len_1", 32'(flush_cycles - fl_snap), 32'd4);

        // 2. Clean frame.
        send_frame(8'h10, -1, 0);
        exp_frames++;
        check("clean_frame_cnt", {16'd0, frame_cnt_o}, 32'(exp_frames));
        check("clean_err", {29'd0, err_o}, 32'd0);
        check("clean_back_to_wait", {31'd0, busy_o}, 32'd0);

        // 3. Short second line.
        vs_pulse(1'b0);
        wait_busy();
        for (int i = 0; i < 4; i++) send_beat(8'h30 + 8'(i), i == 3, 1'b1, i == 0, 0);
        for (int i = 0; i < 3; i++) send_beat(8'h34 + 8'(i), i == 2, 1'b1, 1'b0, 0);
        check("short_line_err", {29'd0, err_o}, 32'b001);
        check("short_line_drop", {31'd0, busy_o}, 32'd0);
        for (int i = 0; i < 5; i++) send_beat(8'h40 + 8'(i), i == 0, 1'b0, 1'b0, 0);
        check("short_line_frame_cnt", {16'd0, frame_cnt_o}, 32'(exp_frames));

        // 4. Short frame; clear collides with the new error, set wins.
        vs_pulse(1'b0);
        wait_busy();
        for (int i = 0; i < 7; i++) send_beat(8'h50 + 8'(i), i == 3, 1'b1, i == 0, 0);
        fl_snap = flush_cycles;
        vs_pulse(1'b1);
        check("short_frame_err", {29'd0, err_o}, 32'b100);
        wait_busy();
        check("flush_len_4", 32'(flush_cycles - fl_snap), 32'd4);
        send_frame(8'h60, -1, 0);
        exp_frames++;
        check("after_short_frame_cnt", {16'd0, frame_cnt_o}, 32'(exp_frames));
        check("err_sticky", {29'd0, err_o}, 32'b100);

        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_cleared", {29'd0, err_o}, 32'd0);

        // 5. Downstream backpressure mid-line.
        vs_pulse(1'b0);
        wait_busy();
        send_frame(8'h70, 5, 3);
        exp_frames++;
        check("stall_frame_cnt", {16'd0, frame_cnt_o}, 32'(exp_frames));
        check("stall_err", {29'd0, err_o}, 32'd0);

        // 6. Long line: last pixel position without tlast.
        vs_pulse(1'b0);
        wait_busy();
        for (int i = 0; i < 4; i++) send_beat(8'h80 + 8'(i), 1'b0, 1'b1, i == 0, 0);
        check("long_line_err", {29'd0, err_o}, 32'b010);
        check("long_line_drop", {31'd0, busy_o}, 32'd0);
        for (int i = 0; i < 2; i++) send_beat(8'h88 + 8'(i), 1'b0, 1'b0, 1'b0, 0);

        // 7. vsync edge coincides with the final beat: frame counts.
        vs_pulse(1'b0);
        wait_busy();
        for (int i = 0; i < 11; i++) send_beat(8'h90 + 8'(i), i % 4 == 3, 1'b1, i == 0, 0);
        fl_snap = flush_cycles;
        vsync = 1'b1;
        send_beat(8'h9B, 1'b1, 1'b1, 1'b0, 0);
        vsync = 1'b0;
        exp_frames++;
        check("coincide_frame_cnt", {16'd0, frame_cnt_o}, 32'(exp_frames));
        check("coincide_err", {29'd0, err_o}, 32'b010);
        check("coincide_flush", {31'd0, flush_o}, 32'd1);
        wait_busy();
        check("coincide_flush_len", 32'(flush_cycles - fl_snap), 32'd4);
        send_frame(8'hC0, -1, 0);
        exp_frames++;
        check("final_frame_cnt", {16'd0, frame_cnt_o}, 32'(exp_frames));

        repeat (3) tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_sobel_frame_ctrl
